// File: rtl/ama_riscv_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous-read IMEM and feeds inst_id/pc_id to ID.
// Latency: 1 cycle from address to inst_id. Stall holds the PC and IMEM output; stall or clear inserts a NOP.
module ama_riscv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_AW      = 14,
    parameter int          CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pc_sel,
    input  logic               pc_we,
    input  logic               stall_if,
    input  logic               clear_if,
    input  logic [31:0]        alu_out,
    input  logic [31:0]        imem_rdata,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        inst_id,
    output logic [31:0]        pc_id,
    output logic               inst_valid_id,
    output logic               fetch_misaligned,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [1:0]  PC_SEL_INC4  = 2'd0;
    localparam logic [1:0]  PC_SEL_ALU   = 2'd1;
    localparam logic [1:0]  PC_SEL_START = 2'd3;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        bubble_q;
    logic        first_q;
    logic        adv;
    logic        id_bubble;

    // The reserved encoding falls through to sequential fetch.
    always_comb begin
        pc_next = pc_q + 32'd4;
        case (pc_sel)
            PC_SEL_START: pc_next = RESET_VECTOR;
            PC_SEL_ALU:   pc_next = alu_out;
            PC_SEL_INC4:  pc_next = pc_q + 32'd4;
            default:      pc_next = pc_q + 32'd4;
        endcase
    end

    assign adv       = pc_we & ~stall_if & ~rst;
    assign imem_en   = adv;
    assign imem_addr = adv ? pc_next[IMEM_AW+1:2] : pc_q[IMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_VECTOR;
            bubble_q         <= 1'b1;
            first_q          <= 1'b1;
            fetch_misaligned <= 1'b0;
        end else begin
            first_q <= 1'b0;
            // Cycle 0 is already covered by the reset value of bubble_q, so
            // the launch fetch issued in that cycle arrives as valid.
            bubble_q <= stall_if | clear_if | ~pc_we;
            if (adv) begin
                pc_q <= pc_next;
                if (pc_next[1:0] != 2'b00) begin
                    fetch_misaligned <= 1'b1;
                end
            end
        end
    end

    assign id_bubble     = bubble_q | first_q;
    assign inst_id       = id_bubble ? NOP : imem_rdata;
    assign inst_valid_id = ~id_bubble;
    assign pc_id         = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (inst_valid_id) begin
            fetch_cnt  <= fetch_cnt + CNT_W'(1);
        end else begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
